// File: rtl/aes_bufmgr_if.sv
// Fill, drain and aesmgr-facing signals of the ping-pong AES packet buffer.
// slave is the buffer side; master is the side that drives the buffer (fill/drain/aesmgr).
interface aes_bufmgr_if #(
    parameter int SBASE = 1,
    parameter int ADDW  = 3
);
    logic             SessStart;
    logic             FillWr;
    logic [31:0]      FillData;
    logic             FillLast;
    logic             FillRdy;
    logic             DrnVld;
    logic             DrnRd;
    logic [31:0]      DrnData;
    logic             DrnLast;
    logic             AesIrdy;
    logic [SBASE:0]   AesSize;
    logic             Sos;
    logic             AesTrdy;
    logic             AesRd;
    logic [ADDW:0]    AesRdAdd;
    logic [31:0]      AesRdData;
    logic             AesWr;
    logic [ADDW:0]    AesWrAdd;
    logic [31:0]      AesWrData;
    logic             ErrPartial;

    modport slave (
        input  SessStart, FillWr, FillData, FillLast, DrnRd, AesTrdy, AesRd,
               AesRdAdd, AesWr, AesWrAdd, AesWrData,
        output FillRdy, DrnVld, DrnData, DrnLast, AesIrdy, AesSize, Sos,
               AesRdData, ErrPartial
    );

    modport master (
        output SessStart, FillWr, FillData, FillLast, DrnRd, AesTrdy, AesRd,
               AesRdAdd, AesWr, AesWrAdd, AesWrData,
        input  FillRdy, DrnVld, DrnData, DrnLast, AesIrdy, AesSize, Sos,
               AesRdData, ErrPartial
    );
endinterface

// File: rtl/aes_bufmgr.sv
// Two-bank ping-pong holding buffer: fill a bank, hand it to aesmgr for in-place
// processing, then drain the results; banks rotate strictly in order.
module aes_bufmgr #(
    parameter int SBASE = 1,
    parameter int ADDW  = 3,
    parameter int NOPKT = 4
) (
    input  logic       clk,
    input  logic       rst,
    aes_bufmgr_if.slave bus
);
    localparam int DEPTH = 4 * NOPKT;

    typedef logic [ADDW:0] widx_t;

    typedef enum logic [2:0] {
        B_FREE,
        B_FILLING,
        B_FULL,
        B_AES,
        B_DONE,
        B_DRAINING
    } bank_st_e;

    bank_st_e       st_q [2];
    widx_t          last_q [2];
    logic           fill_ptr_q, aes_ptr_q, drn_ptr_q;
    widx_t          fill_idx_q, drn_idx_q;
    logic           aes_irdy_q;
    logic [SBASE:0] aes_size_q;
    logic           sos_q, sess_pend_q, err_q;
    logic [31:0]    mem_q [2][DEPTH];

    logic fill_rdy, fill_acc, fill_end;
    logic aes_busy, issue, trdy, aes_wr;
    logic drn_vld, drn_last, drn_acc;
    logic unused_aes_rd;

    assign unused_aes_rd = bus.AesRd;

    assign fill_rdy = (st_q[fill_ptr_q] == B_FREE) || (st_q[fill_ptr_q] == B_FILLING);
    assign fill_acc = bus.FillWr && fill_rdy;
    assign fill_end = bus.FillLast || (fill_idx_q == widx_t'(DEPTH - 1));

    assign aes_busy = (st_q[0] == B_AES) || (st_q[1] == B_AES);
    assign issue    = (st_q[aes_ptr_q] == B_FULL) && !aes_busy;
    assign trdy     = bus.AesTrdy && (st_q[aes_ptr_q] == B_AES);
    assign aes_wr   = bus.AesWr && (st_q[aes_ptr_q] == B_AES);

    // Last drained word is the end of the last packet, so padding words drain too.
    assign drn_vld  = (st_q[drn_ptr_q] == B_DONE) || (st_q[drn_ptr_q] == B_DRAINING);
    assign drn_last = drn_vld && (drn_idx_q == (last_q[drn_ptr_q] | widx_t'(3)));
    assign drn_acc  = bus.DrnRd && drn_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q[0]     <= B_FREE;
            st_q[1]     <= B_FREE;
            last_q[0]   <= '0;
            last_q[1]   <= '0;
            fill_ptr_q  <= 1'b0;
            aes_ptr_q   <= 1'b0;
            drn_ptr_q   <= 1'b0;
            fill_idx_q  <= '0;
            drn_idx_q   <= '0;
            aes_irdy_q  <= 1'b0;
            aes_size_q  <= '0;
            sos_q       <= 1'b0;
            sess_pend_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            aes_irdy_q <= issue;

            // A SessStart in the handoff cycle belongs to this handoff; one seen
            // while AesIrdy is high is kept for the next.
            if (issue) begin
                st_q[aes_ptr_q] <= B_AES;
                aes_size_q      <= (SBASE + 1)'(last_q[aes_ptr_q] >> 2);
                sos_q           <= sess_pend_q | bus.SessStart;
                sess_pend_q     <= 1'b0;
            end else if (bus.SessStart) begin
                sess_pend_q <= 1'b1;
            end

            if (trdy) begin
                st_q[aes_ptr_q] <= B_DONE;
                aes_ptr_q       <= ~aes_ptr_q;
            end

            if (fill_acc) begin
                if (fill_end) begin
                    st_q[fill_ptr_q]   <= B_FULL;
                    last_q[fill_ptr_q] <= fill_idx_q;
                    fill_idx_q         <= '0;
                    fill_ptr_q         <= ~fill_ptr_q;
                    if (bus.FillLast && (fill_idx_q[1:0] != 2'b11)) begin
                        err_q <= 1'b1;
                    end
                end else begin
                    st_q[fill_ptr_q] <= B_FILLING;
                    fill_idx_q       <= fill_idx_q + widx_t'(1);
                end
            end

            if (drn_acc) begin
                if (drn_last) begin
                    st_q[drn_ptr_q] <= B_FREE;
                    drn_idx_q       <= '0;
                    drn_ptr_q       <= ~drn_ptr_q;
                end else begin
                    st_q[drn_ptr_q] <= B_DRAINING;
                    drn_idx_q       <= drn_idx_q + widx_t'(1);
                end
            end
        end
    end

    // Fill and aesmgr always address different banks, so both writes can land together.
    always_ff @(posedge clk) begin
        if (fill_acc) begin
            mem_q[fill_ptr_q][fill_idx_q] <= bus.FillData;
        end
        if (aes_wr) begin
            mem_q[aes_ptr_q][bus.AesWrAdd] <= bus.AesWrData;
        end
    end

    assign bus.FillRdy    = fill_rdy;
    assign bus.DrnVld     = drn_vld;
    assign bus.DrnData    = mem_q[drn_ptr_q][drn_idx_q];
    assign bus.DrnLast    = drn_last;
    assign bus.AesIrdy    = aes_irdy_q;
    assign bus.AesSize    = aes_size_q;
    assign bus.Sos        = sos_q;
    assign bus.AesRdData  = mem_q[aes_ptr_q][bus.AesRdAdd];
    assign bus.ErrPartial = err_q;
endmodule
